keypad_matrix_scanner: RTL and testbench

//   Scans a 4x4 player keypad matrix: drives one column low at a time and reads the rows.

---
 rtl/keypad_matrix_scanner_pkg.sv | 32 +++
 rtl/keypad_matrix_scanner_scan_tick_gen.sv | 29 ++
 rtl/keypad_matrix_scanner.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_matrix_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types and constants for the 4x4 keypad matrix scanner.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    localparam int c_ROW_W = 4;
    localparam int c_COL_W = 4;

    // Game-control legend for key_code (row*4+col)
    localparam logic [3:0] c_KEY_UP    = 4'h1;
    localparam logic [3:0] c_KEY_DOWN  = 4'h9;
    localparam logic [3:0] c_KEY_START = 4'hF;

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2
    } state_t;

    // Index of the lowest-numbered active-low row.
    function automatic logic [1:0] lowest_low(input logic [c_ROW_W-1:0] rows);
        lowest_low = 2'd0;
        for (int i = c_ROW_W - 1; i >= 0; i--) begin
            if (!rows[i]) lowest_low = 2'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_matrix_scanner_scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : scan_tick_gen
//  Purpose  : Free-running prescaler; o_tick is high on the last cycle of
//             every DIV-cycle column dwell.
//  Revision : 1.0  initial release
// ============================================================================
module scan_tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == c_CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)         r_cnt <= '0;
        else if (o_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_matrix_scanner
//  Purpose  : 4x4 keypad column scanner with press/release debounce and a
//             valid/ready key-code output. Optional build macro
//             KEYPAD_AUTOREPEAT_EN adds auto-repeat while a key is held.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 200,
    parameter int REPEAT_RATE    = 50
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [c_ROW_W-1:0] row_in,
    output logic [c_COL_W-1:0] col_out,
    output logic [3:0]         key_code,
    output logic               key_valid,
    input  logic               key_ready,
    output logic               key_held,
    output logic               overflow
);

    localparam int c_CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEBOUNCE_SCANS);

    logic               w_tick;
    logic [c_ROW_W-1:0] r_sync1, r_sync2;
    state_t             r_state, w_state_nxt;
    logic [1:0]         r_col_idx, w_col_nxt;
    logic [1:0]         r_cap_row, w_cap_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic               w_row_low;
    logic               w_fsm_accept, w_rep_fire, w_accept;
    logic [3:0]         w_key_code;
    logic [3:0]         r_key_code;
    logic               r_key_valid, r_overflow;

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= row_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_row_low  = ~r_sync2[r_cap_row];
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_key_code = {w_cap_nxt, r_col_idx};

    always_comb begin
        w_state_nxt  = r_state;
        w_col_nxt    = r_col_idx;
        w_cap_nxt    = r_cap_row;
        w_cnt_nxt    = r_cnt;
        w_fsm_accept = 1'b0;
        case (r_state)
            S_SCAN: begin
                if (w_tick) begin
                    if (r_sync2 != '1) begin
                        w_cap_nxt = lowest_low(r_sync2);
                        if (DEBOUNCE_SCANS == 1) begin
                            w_fsm_accept = 1'b1;
                            w_state_nxt  = S_PRESSED;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_state_nxt  = S_DEBOUNCE;
                            w_cnt_nxt    = c_CNT_W'(1);
                        end
                    end else begin
                        w_col_nxt = r_col_idx + 2'd1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (w_tick) begin
                    if (w_row_low) begin
                        if (w_cnt_inc == c_DEB_LAST) begin
                            w_fsm_accept = 1'b1;
                            w_state_nxt  = S_PRESSED;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_cnt_nxt    = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = S_SCAN;
                        w_col_nxt   = r_col_idx + 2'd1;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_PRESSED: begin
                // r_cnt now counts consecutive released ticks
                if (w_tick) begin
                    if (!w_row_low) begin
                        if (w_cnt_inc == c_DEB_LAST) begin
                            w_state_nxt = S_SCAN;
                            w_col_nxt   = r_col_idx + 2'd1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_SCAN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_SCAN;
            r_col_idx <= 2'd0;
            r_cap_row <= 2'd0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_idx <= w_col_nxt;
            r_cap_row <= w_cap_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    logic [c_REP_W-1:0] r_rep_cnt, w_rep_inc, w_rep_target;
    logic               r_rep_first, w_rep_step;

    assign w_rep_inc    = r_rep_cnt + 1'b1;
    assign w_rep_target = r_rep_first ? c_REP_W'(REPEAT_DELAY) : c_REP_W'(REPEAT_RATE);
    assign w_rep_step   = (r_state == S_PRESSED) && w_tick && w_row_low;
    assign w_rep_fire   = w_rep_step && (w_rep_inc == w_rep_target);

    // Any released tick restarts the hold timer from the initial delay
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_PRESSED) || (w_tick && !w_row_low)) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else if (w_rep_step) begin
            r_rep_cnt   <= w_rep_inc;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign w_accept = w_fsm_accept | w_rep_fire;

    // A completed handshake and a new accept on the same cycle keep valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (w_accept) begin
                if (!r_key_valid || key_ready) begin
                    r_key_code  <= w_key_code;
                    r_key_valid <= 1'b1;
                end else begin
                    r_overflow  <= 1'b1;
                end
            end else if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign col_out   = ~(4'b0001 << r_col_idx);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign overflow  = r_overflow;
    assign key_held  = (r_state == S_PRESSED);

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_matrix_scanner
//  Purpose  : Directed bench for keypad_matrix_scanner (SCAN_DIV=4,
//             DEBOUNCE_SCANS=3) driving a modelled keypad switch matrix.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_matrix_scanner;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int c_EXP_HS = 5;
`else
    localparam int c_EXP_HS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_held;
    logic        overflow;
    logic [15:0] pressed;   // bit r*4+c = switch at row r, column c closed

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;       // clk edges since the last reset edge
    int hs;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (5),
        .REPEAT_RATE    (2)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    // Closed switch pulls its row low while its column is driven low
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic to_k(input int t);
        while (k < t) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        pressed = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        k   = 0;
    endtask

    initial begin
        rst       = 1'b1;
        key_ready = 1'b1;
        pressed   = '0;

        // Reset state and idle column rotation
        do_reset();
        chk("rst_col", col_out, 4'b1110);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        to_k(4);  chk("scan_c1", col_out, 4'b1101);
        to_k(8);  chk("scan_c2", col_out, 4'b1011);
        to_k(12); chk("scan_c3", col_out, 4'b0111);
        to_k(16); chk("scan_c0", col_out, 4'b1110);

        // Clean press of row 1 / col 2 with consumer ready
        do_reset();
        pressed[6] = 1'b1;
        to_k(16); chk("t2_frozen_col", col_out, 4'b1011);
        to_k(19); chk("t2_valid_early", key_valid, 1'b0);
        to_k(20);
        chk("t2_valid", key_valid, 1'b1);
        chk("t2_code", key_code, 4'h6);
        chk("t2_held", key_held, 1'b1);
        to_k(21);
        chk("t2_valid_clr", key_valid, 1'b0);
        pressed = '0;
        to_k(31); chk("t2_held_rel", key_held, 1'b1);
        to_k(32);
        chk("t2_held_off", key_held, 1'b0);
        chk("t2_next_col", col_out, 4'b0111);

        // Press lasting only two ticks is rejected
        do_reset();
        pressed[6] = 1'b1;
        to_k(16);
        pressed = '0;
        to_k(19); chk("t3_col_hold", col_out, 4'b1011);
        to_k(20);
        chk("t3_col3", col_out, 4'b0111);
        chk("t3_valid", key_valid, 1'b0);
        chk("t3_held", key_held, 1'b0);

        // Second accept while first key still pending
        key_ready = 1'b0;
        do_reset();
        pressed[6] = 1'b1;
        to_k(20);
        chk("t4_valid", key_valid, 1'b1);
        chk("t4_code", key_code, 4'h6);
        to_k(21);
        pressed = 16'h0001;
        to_k(32); chk("t4_col3", col_out, 4'b0111);
        to_k(47);
        chk("t4_ovf_early", overflow, 1'b0);
        chk("t4_valid_hold", key_valid, 1'b1);
        to_k(48);
        chk("t4_ovf", overflow, 1'b1);
        chk("t4_code_kept", key_code, 4'h6);
        chk("t4_held0", key_held, 1'b1);
        to_k(49);
        chk("t4_ovf_pulse", overflow, 1'b0);
        key_ready = 1'b1;
        to_k(50);
        chk("t4_valid_drop", key_valid, 1'b0);

        // Two rows in column 0: lowest row wins
        do_reset();
        pressed = 16'h0101;
        to_k(11); chk("t5_valid_early", key_valid, 1'b0);
        to_k(12);
        chk("t5_valid", key_valid, 1'b1);
        chk("t5_code", key_code, 4'h0);

        // Captured row released mid-debounce; the other low row is ignored
        do_reset();
        pressed = 16'h0101;
        to_k(4);
        pressed[0] = 1'b0;
        to_k(8);
        chk("t5b_col1", col_out, 4'b1101);
        chk("t5b_held", key_held, 1'b0);
        pressed = '0;
        to_k(24); chk("t5b_valid", key_valid, 1'b0);

        // Reset during debounce restarts the count from zero
        do_reset();
        pressed[6] = 1'b1;
        to_k(16);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        k   = 0;
        chk("t6_col", col_out, 4'b1110);
        chk("t6_valid", key_valid, 1'b0);
        chk("t6_held", key_held, 1'b0);
        to_k(19); chk("t6_valid_early", key_valid, 1'b0);
        to_k(20);
        chk("t6_valid_late", key_valid, 1'b1);
        chk("t6_code", key_code, 4'h6);

        // 12-tick hold after accept: count handshakes
        do_reset();
        pressed[6] = 1'b1;
        hs = 0;
        for (int t = 1; t <= 100; t++) begin
            to_k(t);
            if (key_valid && key_ready) hs++;
            if (t == 68) pressed = '0;
        end
        chk("t7_handshakes", hs, c_EXP_HS);
        chk("t7_held_off", key_held, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
